// File: rtl/pipe_advance_ctrl.sv
// pipe_advance_ctrl
//   Pipeline front-end control. Owns the fetch PC and the ID/EX/MEM/WB
//   instruction registers with their R/I-type flags, inserts a bubble into
//   EX while ID is stalled, squashes IF/ID on a taken branch, counts
//   stalled cycles (saturating) and raises a sticky watchdog error after
//   MAX_STALL consecutive stalled cycles.
// Ports
//   clk                       rising-edge clock
//   reset                     synchronous reset, active low
//   stall                     1 = advance, 0 = hold ID (from the stall unit)
//   imem_valid, imem_data     fetched instruction at pc
//   branch_taken/_target      redirect fetch, squash IF/ID
//   pc                        current fetch address
//   IRD/IREX/IRMEM/IRWB       per-stage instruction (0 = NOP)
//   is_r_type_*, is_i_type_*  per-stage decode flags
//   stall_cycles              saturating stalled-cycle count
//   wdog_err                  sticky watchdog error
// Every output comes straight from a flop, so the stall unit cannot
// close a combinational loop through this block.
module pipe_advance_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_valid,
  input  logic [31:0]      imem_data,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc,
  output logic [31:0]      IRD,
  output logic [31:0]      IREX,
  output logic [31:0]      IRMEM,
  output logic [31:0]      IRWB,
  output logic             is_r_type_ID,
  output logic             is_r_type_EXE,
  output logic             is_r_type_MEM,
  output logic             is_r_type_WB,
  output logic             is_i_type_ID,
  output logic             is_i_type_EXE,
  output logic             is_i_type_MEM,
  output logic             is_i_type_WB,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wdog_err
);

  localparam int CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_STALL);

  // Stage index 0..3 = ID, EX, MEM, WB
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q [0:3];
  logic [31:0]      ir_d [0:3];
  logic [3:0]       r_q, r_d;
  logic [3:0]       i_q, i_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic [CW-1:0]    consec_q, consec_d;
  logic             wdog_q, wdog_d;

  logic [5:0] fetch_op;
  logic       fetch_r, fetch_i;

  // Decode happens only once, on entry to ID; flags then travel with the IR.
  assign fetch_op = imem_data[31:26];
  assign fetch_r  = (fetch_op == 6'h00) && (imem_data != 32'h0);
  assign fetch_i  = (fetch_op != 6'h00) && (fetch_op != 6'h02) && (fetch_op != 6'h03);

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    r_d      = r_q;
    i_d      = i_q;
    sc_d     = sc_q;
    consec_d = consec_q;
    wdog_d   = wdog_q;

    // MEM and WB always move forward, whatever happens upstream.
    ir_d[3] = ir_q[2];
    ir_d[2] = ir_q[1];
    r_d[3]  = r_q[2];
    r_d[2]  = r_q[1];
    i_d[3]  = i_q[2];
    i_d[2]  = i_q[1];

    if (branch_taken) begin
      // Squash whatever sits in IF/ID; a redirect is not a stall.
      pc_d     = branch_target;
      ir_d[0]  = 32'h0;
      ir_d[1]  = 32'h0;
      r_d[1:0] = 2'b00;
      i_d[1:0] = 2'b00;
      consec_d = '0;
    end else if (!stall) begin
      // ID holds, EX receives a bubble.
      ir_d[1] = 32'h0;
      r_d[1]  = 1'b0;
      i_d[1]  = 1'b0;
      if (sc_q != {CNT_W{1'b1}}) sc_d = sc_q + 1'b1;
      if (consec_q != CONSEC_MAX) consec_d = consec_q + 1'b1;
      if (consec_d == CONSEC_MAX) wdog_d = 1'b1;
    end else begin
      ir_d[1] = ir_q[0];
      r_d[1]  = r_q[0];
      i_d[1]  = i_q[0];
      consec_d = '0;
      if (imem_valid) begin
        pc_d    = pc_q + 32'd4;
        ir_d[0] = imem_data;
        r_d[0]  = fetch_r;
        i_d[0]  = fetch_i;
      end else begin
        ir_d[0] = 32'h0;
        r_d[0]  = 1'b0;
        i_d[0]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q[0]  <= 32'h0;
      ir_q[1]  <= 32'h0;
      ir_q[2]  <= 32'h0;
      ir_q[3]  <= 32'h0;
      r_q      <= '0;
      i_q      <= '0;
      sc_q     <= '0;
      consec_q <= '0;
      wdog_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      r_q      <= r_d;
      i_q      <= i_d;
      sc_q     <= sc_d;
      consec_q <= consec_d;
      wdog_q   <= wdog_d;
    end
  end

  assign pc            = pc_q;
  assign IRD           = ir_q[0];
  assign IREX          = ir_q[1];
  assign IRMEM         = ir_q[2];
  assign IRWB          = ir_q[3];
  assign is_r_type_ID  = r_q[0];
  assign is_r_type_EXE = r_q[1];
  assign is_r_type_MEM = r_q[2];
  assign is_r_type_WB  = r_q[3];
  assign is_i_type_ID  = i_q[0];
  assign is_i_type_EXE = i_q[1];
  assign is_i_type_MEM = i_q[2];
  assign is_i_type_WB  = i_q[3];
  assign stall_cycles  = sc_q;
  assign wdog_err      = wdog_q;

endmodule

// File: tb/tb_pipe_advance_ctrl.sv
// Bench for pipe_advance_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a stage-list model.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_pipe_advance_ctrl;

  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        rst_n, stall, iv, bt;
  logic [31:0] idata, tgt;

  logic [31:0] pc, ird, irex, irmem, irwb;
  logic        r_id, r_ex, r_mem, r_wb, i_id, i_ex, i_mem, i_wb;
  logic [15:0] sc;
  logic        wd;

  logic [31:0] b_pc, b_ird, b_irex, b_irmem, b_irwb;
  logic        b_r_id, b_r_ex, b_r_mem, b_r_wb, b_i_id, b_i_ex, b_i_mem, b_i_wb;
  logic [3:0]  b_sc;
  logic        b_wd;

  always #5 clk = ~clk;

  pipe_advance_ctrl #(.RESET_PC(32'h0), .CNT_W(16), .MAX_STALL(MAXS)) dut (
    .clk(clk), .reset(rst_n), .stall(stall), .imem_valid(iv), .imem_data(idata),
    .branch_taken(bt), .branch_target(tgt), .pc(pc),
    .IRD(ird), .IREX(irex), .IRMEM(irmem), .IRWB(irwb),
    .is_r_type_ID(r_id), .is_r_type_EXE(r_ex), .is_r_type_MEM(r_mem), .is_r_type_WB(r_wb),
    .is_i_type_ID(i_id), .is_i_type_EXE(i_ex), .is_i_type_MEM(i_mem), .is_i_type_WB(i_wb),
    .stall_cycles(sc), .wdog_err(wd)
  );

  pipe_advance_ctrl #(.RESET_PC(32'h0), .CNT_W(4), .MAX_STALL(MAXS)) dut4 (
    .clk(clk), .reset(rst_n), .stall(stall), .imem_valid(iv), .imem_data(idata),
    .branch_taken(bt), .branch_target(tgt), .pc(b_pc),
    .IRD(b_ird), .IREX(b_irex), .IRMEM(b_irmem), .IRWB(b_irwb),
    .is_r_type_ID(b_r_id), .is_r_type_EXE(b_r_ex), .is_r_type_MEM(b_r_mem), .is_r_type_WB(b_r_wb),
    .is_i_type_ID(b_i_id), .is_i_type_EXE(b_i_ex), .is_i_type_MEM(b_i_mem), .is_i_type_WB(b_i_wb),
    .stall_cycles(b_sc), .wdog_err(b_wd)
  );

  // ---------------- reference model ----------------
  // Stage contents as a plain list; flags are derived from the instruction.
  logic [31:0] m_pc;
  logic [31:0] m_ir [0:3];
  int          m_sc, m_sc4, m_consec;
  bit          m_wd;
  bit          chk_en = 1'b0;
  int          n_vec = 0, n_err = 0;

  function automatic bit is_r(input logic [31:0] x);
    return (x[31:26] == 6'd0) && (x != 32'd0);
  endfunction

  function automatic bit is_i(input logic [31:0] x);
    logic [5:0] op;
    op = x[31:26];
    return !(op == 6'd0 || op == 6'd2 || op == 6'd3);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_pc = 32'h0;
      for (int k = 0; k < 4; k++) m_ir[k] = 32'h0;
      m_sc = 0; m_sc4 = 0; m_consec = 0; m_wd = 1'b0;
    end else begin
      m_ir[3] = m_ir[2];
      m_ir[2] = m_ir[1];
      if (bt) begin
        m_pc = tgt; m_ir[1] = 32'h0; m_ir[0] = 32'h0; m_consec = 0;
      end else if (!stall) begin
        m_ir[1] = 32'h0;
        m_sc  = (m_sc  < 65535) ? m_sc + 1 : 65535;
        m_sc4 = (m_sc4 < 15)    ? m_sc4 + 1 : 15;
        m_consec++;
        if (m_consec >= MAXS) m_wd = 1'b1;
      end else begin
        m_ir[1] = m_ir[0];
        m_ir[0] = iv ? idata : 32'h0;
        if (iv) m_pc = m_pc + 32'd4;
        m_consec = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("IRD", ird, m_ir[0]);
      chk("IREX", irex, m_ir[1]);
      chk("IRMEM", irmem, m_ir[2]);
      chk("IRWB", irwb, m_ir[3]);
      chk("r_flags", {31'd0, r_id} | {30'd0, r_ex, 1'b0} | {29'd0, r_mem, 2'b0} | {28'd0, r_wb, 3'b0},
          {28'd0, is_r(m_ir[3]), is_r(m_ir[2]), is_r(m_ir[1]), is_r(m_ir[0])});
      chk("i_flags", {28'd0, i_wb, i_mem, i_ex, i_id},
          {28'd0, is_i(m_ir[3]), is_i(m_ir[2]), is_i(m_ir[1]), is_i(m_ir[0])});
      chk("stall_cycles", {16'd0, sc}, m_sc);
      chk("wdog_err", {31'd0, wd}, {31'd0, m_wd});
      chk("sc4", {28'd0, b_sc}, m_sc4);
      chk("wdog4", {31'd0, b_wd}, {31'd0, m_wd});
      chk("pc4", b_pc, m_pc);
    end
  end

  // One clock: inputs applied at a falling edge, model follows the rising edge.
  task automatic tick(input bit r, input bit s, input bit v, input logic [31:0] d,
                      input bit b, input logic [31:0] t);
    rst_n = r; stall = s; iv = v; idata = d; bt = b; tgt = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD = 32'h012A4020;
  localparam logic [31:0] LW  = 32'h8C220004;
  localparam logic [31:0] JMP = 32'h08000010;
  localparam logic [31:0] ORI = 32'h34010005;

  initial begin
    rst_n = 1'b0; stall = 1'b1; iv = 1'b0; idata = 32'h0; bt = 1'b0; tgt = 32'h0;

    // 1: reset with random inputs
    tick(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
    chk_en = 1'b1;
    tick(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ird | irex | irmem | irwb, 32'h0);
    chk("rst_flags", {28'd0, r_id, r_wb, i_id, i_wb}, 32'h0);
    chk("rst_sc", {16'd0, sc}, 32'h0);
    chk("rst_wd", {31'd0, wd}, 32'h0);

    // 2: add flows to WB in 3 more edges, pc advances by 4 per fetch
    tick(1'b1, 1'b1, 1'b1, ADD, 1'b0, 32'h0);
    chk("t2_IRD", ird, ADD);
    chk("t2_rID", {31'd0, r_id}, 32'd1);
    tick(1'b1, 1'b1, 1'b1, LW, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, JMP, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, ORI, 1'b0, 32'h0);
    chk("t2_IRWB", irwb, ADD);
    chk("t2_rWB", {31'd0, r_wb}, 32'd1);
    chk("t2_pc", pc, 32'h10);
    chk("t2_iMEM", {30'd0, i_mem, i_ex}, 32'd2);   // lw is I, jump is neither

    // 3: one stall cycle with IRD=ORI, IREX=JMP
    tick(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("t3_pc", pc, 32'h10);
    chk("t3_IRD", ird, ORI);
    chk("t3_IREX", irex, 32'h0);
    chk("t3_IRMEM", irmem, JMP);
    chk("t3_sc", {16'd0, sc}, 32'd1);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t3_resume", irex, ORI);

    // 4: branch wins over stall
    tick(1'b1, 1'b0, 1'b1, LW, 1'b1, 32'h40);
    chk("t4_pc", pc, 32'h40);
    chk("t4_IRD", ird, 32'h0);
    chk("t4_IREX", irex, 32'h0);
    chk("t4_sc", {16'd0, sc}, 32'd1);

    // 5: watchdog threshold
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_wd7", {31'd0, wd}, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_wd7b", {31'd0, wd}, 32'd0);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_wd8", {31'd0, wd}, 32'd1);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_sticky", {31'd0, wd}, 32'd1);

    // 6: counter saturation and fetch bubble
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_sc16", {16'd0, sc}, 32'd20);
    chk("t6_sc4", {28'd0, b_sc}, 32'd15);
    tick(1'b1, 1'b1, 1'b0, LW, 1'b0, 32'h0);
    chk("t6_pc", pc, 32'h40);
    chk("t6_IRD", ird, 32'h0);

    // Randomized traffic with stall bursts long enough to trip the watchdog.
    begin
      int burst = 0;
      logic [31:0] d;
      for (int n = 0; n < 3000; n++) begin
        bit r, s, v, b;
        if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 12);
        s = (burst > 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
        if (burst > 0) burst--;
        r = ($urandom_range(0, 299) != 0);
        v = ($urandom_range(0, 3) != 0);
        b = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
          0: d = 32'h0;
          1: d = {6'd0, 26'($urandom)};
          2: d = {5'd1, 1'($urandom), 26'($urandom)};
          default: d = $urandom;
        endcase
        tick(r, s, v, d, b, {$urandom_range(0, 32'hFFFF) , 2'b00} == 34'd0 ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2);
      end
    end

    // Wrap of pc at the top of the address space.
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick(1'b1, 1'b1, 1'b1, ADD, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
